// File: rtl/fir_interp_serial.sv
// Polyphase x L interpolating FIR built around one time-shared multiplier-accumulator.
// Each accepted sample yields L outputs, phase 0 first, spaced D+1 enabled cycles apart.
module fir_interp_serial #(
    parameter int tap_len = 21,
    parameter int L       = 4,
    parameter int OSHIFT  = 14
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cke,
    input  logic signed [15:0]         din,
    input  logic                       din_vld,
    output logic                       din_rdy,
    output logic signed [15:0]         dout,
    output logic                       dout_vld,
    input  logic [tap_len-1:0][15:0]   tap
);

    localparam int D  = (tap_len + L - 1) / L;
    localparam int KW = (D > 1) ? $clog2(D) : 1;
    localparam int PW = $clog2(L);
    localparam int IW = $clog2(D * L);
    localparam int AW = 32 + $clog2(D);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_OUT  = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [PW-1:0]          phase_q, phase_d;
    logic [KW-1:0]          k_q, k_d;
    logic signed [AW-1:0]   acc_q, acc_d;
    logic signed [15:0]     x_q [D];
    logic signed [15:0]     x_d [D];
    logic signed [15:0]     dout_q, dout_d;
    logic                   dout_vld_q, dout_vld_d;
    logic                   din_rdy_q, din_rdy_d;

    logic [IW-1:0]          idx_s;
    logic signed [15:0]     coef_s;
    logic signed [15:0]     x_sel_s;
    logic signed [31:0]     prod_s;

    // Clamp a wide signed value into the 16-bit output range.
    function automatic logic signed [15:0] sat16(input logic signed [AW-1:0] v);
        logic signed [15:0] r;
        if ((&v[AW-1:15]) || (~|v[AW-1:15])) begin
            r = v[15:0];
        end else if (v[AW-1]) begin
            r = 16'sh8000;
        end else begin
            r = 16'sh7fff;
        end
        return r;
    endfunction

    // Coefficient and delay-line operand selection for the current product.
    always_comb begin
        idx_s   = IW'(int'(k_q) * L + int'(phase_q));
        coef_s  = 16'sd0;
        x_sel_s = 16'sd0;
        for (int i = 0; i < tap_len; i++) begin
            coef_s = (idx_s == IW'(i)) ? $signed(tap[i]) : coef_s;
        end
        for (int i = 0; i < D; i++) begin
            x_sel_s = (k_q == KW'(i)) ? x_q[i] : x_sel_s;
        end
        prod_s = 32'(coef_s) * 32'(x_sel_s);
    end

    // Next-state and datapath updates for the IDLE / MAC / OUT sequence.
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        k_d        = k_q;
        acc_d      = acc_q;
        x_d        = x_q;
        dout_d     = dout_q;
        dout_vld_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (din_vld && din_rdy_q) begin
                    x_d[0] = din;
                    for (int i = 1; i < D; i++) begin
                        x_d[i] = x_q[i-1];
                    end
                    phase_d = PW'(0);
                    k_d     = KW'(0);
                    acc_d   = AW'(0);
                    state_d = ST_MAC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MAC: begin
                acc_d = acc_q + AW'(prod_s);
                if (k_q == KW'(D - 1)) begin
                    state_d = ST_OUT;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            ST_OUT: begin
                dout_d     = sat16(acc_q >>> OSHIFT);
                dout_vld_d = 1'b1;
                if (phase_q != PW'(L - 1)) begin
                    phase_d = phase_q + PW'(1);
                    k_d     = KW'(0);
                    acc_d   = AW'(0);
                    state_d = ST_MAC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        din_rdy_d = (state_d == ST_IDLE);
    end

    // State register; everything freezes while cke is low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            phase_q    <= PW'(0);
            k_q        <= KW'(0);
            acc_q      <= AW'(0);
            for (int i = 0; i < D; i++) begin
                x_q[i] <= 16'sd0;
            end
            dout_q     <= 16'sd0;
            dout_vld_q <= 1'b0;
            din_rdy_q  <= 1'b1;
        end else if (cke) begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            k_q        <= k_d;
            acc_q      <= acc_d;
            x_q        <= x_d;
            dout_q     <= dout_d;
            dout_vld_q <= dout_vld_d;
            din_rdy_q  <= din_rdy_d;
        end
    end

    // A strobe held over a frozen cycle is hidden until the clock is enabled again.
    assign dout     = dout_q;
    assign dout_vld = dout_vld_q & cke;
    assign din_rdy  = din_rdy_q;

endmodule

// File: tb/tb_fir_interp_serial.sv
// Randomised scoreboard bench for fir_interp_serial against a plain-arithmetic polyphase model.
module tb_fir_interp_serial;

    localparam int TAP_LEN = 21;
    localparam int LF      = 4;
    localparam int OSH     = 14;
    localparam int D       = (TAP_LEN + LF - 1) / LF;

    logic                      clk;
    logic                      rst;
    logic                      cke;
    logic signed [15:0]        din;
    logic                      din_vld;
    logic                      din_rdy;
    logic signed [15:0]        dout;
    logic                      dout_vld;
    logic [TAP_LEN-1:0][15:0]  tap;

    int h_ref [TAP_LEN] = '{0, -139, -416, -764, -813, 0, 2091, 5359, 9048, 11985, 13107,
                            11985, 9048, 5359, 2091, 0, -813, -764, -416, -139, 0};

    int passed = 0;
    int total  = 0;
    int exp_q[$];
    int hist[$];
    int cyc = 0;
    int ecyc = 0;
    int xfer_cyc = 0;
    int xfer_ecyc = 0;
    int pend_cyc = 0;
    int pend_ecyc = 0;
    int pend_din = 0;
    bit xfer_seen = 1'b0;
    bit cke_mode = 1'b0;
    int strobe_idx = 0;
    int last_ph0 = 0;
    int last_burst [LF];

    fir_interp_serial #(.tap_len(TAP_LEN), .L(LF), .OSHIFT(OSH)) dut (
        .clk      (clk),
        .rst      (rst),
        .cke      (cke),
        .din      (din),
        .din_vld  (din_vld),
        .din_rdy  (din_rdy),
        .dout     (dout),
        .dout_vld (dout_vld),
        .tap      (tap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input bit ok, input string name, input int act, input int expv);
        total++;
        if (ok) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, expv);
    endtask

    // Reference: y[nL+p] = sat(floor(sum_k h[kL+p] * x[n-k] / 2^OSH)).
    function automatic void model_push(input int v);
        longint acc;
        int     y;
        hist.push_front(v);
        if (hist.size() > D) void'(hist.pop_back());
        for (int p = 0; p < LF; p++) begin
            acc = 0;
            for (int k = 0; k < hist.size(); k++) begin
                if (k * LF + p < TAP_LEN) acc += longint'(h_ref[k * LF + p]) * longint'(hist[k]);
            end
            acc = acc >>> OSH;
            if (acc > 32767) y = 32767;
            else if (acc < -32768) y = -32768;
            else y = int'(acc);
            exp_q.push_back(y);
        end
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (cke) ecyc++;
    end

    always @(posedge clk) begin
        #1;
        cke = cke_mode ? ~cke : 1'b1;
    end

    // Spot the handshake cycle; the driver pushes the expectation once the edge has passed.
    always @(negedge clk) begin
        xfer_seen = 1'b0;
        if (rst && cke && din_vld && din_rdy) begin
            xfer_seen = 1'b1;
            pend_din  = int'(din);
            pend_cyc  = cyc;
            pend_ecyc = ecyc;
        end
    end

    // Monitor: pop and compare on each visible strobe.
    always @(negedge clk) begin : mon
        int e;
        int off;
        if (!cke) chk(dout_vld == 1'b0, "vld_cke_low", int'(dout_vld), 0);
        if (rst && dout_vld) begin
            if (exp_q.size() == 0) begin
                chk(1'b0, "unexpected_vld", int'(dout), 0);
            end else begin
                e = exp_q.pop_front();
                chk(int'(dout) == e, "dout", int'(dout), e);
                off = (D + 2) + (D + 1) * strobe_idx;
                chk(ecyc - xfer_ecyc == off, "strobe_time", ecyc - xfer_ecyc, off);
                if (cke_mode && strobe_idx == LF - 1)
                    chk(cyc - xfer_cyc >= 2 * off - 2, "cke_wall", cyc - xfer_cyc, 2 * off - 2);
                if (strobe_idx < LF) last_burst[strobe_idx] = int'(dout);
                if (strobe_idx == 0) last_ph0 = int'(dout);
            end
            strobe_idx++;
        end
    end

    task automatic send(input int v, input bit keep);
        bit ok;
        ok = 1'b0;
        din = 16'(v);
        din_vld = 1'b1;
        for (int g = 0; g < 400; g++) begin
            @(posedge clk);
            if (xfer_seen) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            model_push(pend_din);
            xfer_cyc   = pend_cyc;
            xfer_ecyc  = pend_ecyc;
            strobe_idx = 0;
        end else begin
            chk(1'b0, "accept_timeout", 0, 1);
        end
        #1;
        if (!keep) din_vld = 1'b0;
    endtask

    task automatic drain();
        for (int g = 0; g < 600; g++) begin
            @(negedge clk);
            if (exp_q.size() == 0) break;
        end
        chk(exp_q.size() == 0, "drain", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int prev;
        rst = 1'b0;
        cke = 1'b1;
        din = 16'sd0;
        din_vld = 1'b0;
        for (int i = 0; i < TAP_LEN; i++) tap[i] = 16'(h_ref[i]);
        #12;
        chk(dout == 16'sd0, "rst_dout", int'(dout), 0);
        chk(dout_vld == 1'b0, "rst_vld", int'(dout_vld), 0);
        chk(din_rdy == 1'b1, "rst_rdy", int'(din_rdy), 1);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Impulse response walks through the taps
        send(16384, 1'b0);
        for (int i = 0; i < 5; i++) send(0, 1'b0);
        drain();

        // DC, back-to-back
        for (int i = 0; i < 8; i++) send(8000, 1'b1);
        din_vld = 1'b0;
        drain();
        chk(last_ph0 == 8041, "dc_ph0", last_ph0, 8041);

        // Saturation both ways
        for (int i = 0; i < 7; i++) send(32767, 1'b1);
        din_vld = 1'b0;
        drain();
        chk(last_ph0 == 32767, "sat_pos", last_ph0, 32767);
        for (int i = 0; i < 7; i++) send(-32768, 1'b1);
        din_vld = 1'b0;
        drain();
        chk(last_ph0 == -32768, "sat_neg", last_ph0, -32768);

        // Random data with din_vld held high
        prev = 0;
        for (int i = 0; i < 10; i++) begin
            send(int'($urandom_range(65535)) - 32768, 1'b1);
            if (i > 0) chk(xfer_cyc - prev == (D + 1) * LF + 1, "xfer_interval", xfer_cyc - prev, (D + 1) * LF + 1);
            prev = xfer_cyc;
        end
        din_vld = 1'b0;
        drain();

        // Random data with the clock enable toggling every cycle
        cke_mode = 1'b1;
        for (int i = 0; i < 4; i++) send(int'($urandom_range(65535)) - 32768, 1'b0);
        drain();
        cke_mode = 1'b0;
        @(posedge clk);
        #1;

        // Reset during the third MAC cycle of phase 1
        send(int'($urandom_range(65535)) - 32768, 1'b0);
        send(int'($urandom_range(65535)) - 32768, 1'b0);
        for (int g = 0; g < 100; g++) begin
            @(negedge clk);
            if (dout_vld) break;
        end
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b0;
        exp_q.delete();
        hist.delete();
        #1;
        chk(dout == 16'sd0, "mid_rst_dout", int'(dout), 0);
        chk(dout_vld == 1'b0, "mid_rst_vld", int'(dout_vld), 0);
        chk(din_rdy == 1'b1, "mid_rst_rdy", int'(din_rdy), 1);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        send(16384, 1'b0);
        drain();
        chk(last_burst[1] == -139, "post_rst_p1", last_burst[1], -139);
        chk(last_burst[3] == -764, "post_rst_p3", last_burst[3], -764);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
